ibex_dummy_reseed_ctrl: RTL and testbench

Controller that sequences reseeding of the dummy-instruction LFSR from an entropy source (EDN-style req/ack). It counts inserted dummy instructions and requests fresh entropy after a programmable interval or when insertion is enabled. It arbitrates between software seed writes and hardware entropy loads onto the single seed-load port. It sits between the CSR file and the dummy-instruction generator, drives that generator's enable/mask/seed inputs, and suppresses insertion while a reseed is being applied.

---
 rtl/ibex_dummy_reseed_ctrl.sv | 152 +++++++++++++++
 tb/tb_ibex_dummy_reseed_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_dummy_reseed_ctrl.sv
// Reseed controller for the dummy-instruction LFSR.
// Counts inserted dummy instructions and requests fresh entropy over an
// EDN-style req/ack handshake, either after a programmable number of
// insertions or on a rising edge of the software enable. Hardware entropy
// loads and software seed writes share one seed-load port. Software writes
// take priority, and a deferred EDN load follows one cycle later. Insertion
// is suppressed in every cycle in which the LFSR is being loaded.
module ibex_dummy_reseed_ctrl #(
  parameter int unsigned ReseedIntervalW = 16,
  parameter bit          ReseedOnEnable  = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       csr_dummy_en_i,
  input  logic [2:0]                 csr_dummy_mask_i,
  input  logic [ReseedIntervalW-1:0] csr_reseed_interval_i,
  input  logic                       csr_seed_wr_i,
  input  logic [31:0]                csr_seed_i,
  input  logic                       dummy_inserted_i,
  output logic                       edn_req_o,
  input  logic                       edn_ack_i,
  input  logic [31:0]                edn_data_i,
  output logic                       dummy_instr_en_o,
  output logic [2:0]                 dummy_instr_mask_o,
  output logic                       dummy_instr_seed_en_o,
  output logic [31:0]                dummy_instr_seed_o,
  output logic                       reseed_busy_o,
  output logic [7:0]                 reseed_cnt_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StLoad = 2'd2;

  localparam logic [ReseedIntervalW-1:0] InsOne = ReseedIntervalW'(1);

  logic [1:0]                 r_state;
  logic [1:0]                 w_state_d;
  logic                       r_edn_req;
  logic                       r_en_q;
  logic [2:0]                 r_mask;
  logic [ReseedIntervalW-1:0] r_ins_cnt;
  logic [31:0]                r_seed_buf;
  logic                       r_sw_pend;
  logic [31:0]                r_sw_seed;
  logic [7:0]                 r_reseed_cnt;

  logic w_en_rise;
  logic w_interval_hit;
  logic w_trigger;
  logic w_in_load;
  logic w_load_done;

  // Reseed triggers: interval reached (0 disables) or enable rising edge.
  assign w_en_rise      = ReseedOnEnable & csr_dummy_en_i & ~r_en_q;
  assign w_interval_hit = (csr_reseed_interval_i != '0) &&
                          (r_ins_cnt >= csr_reseed_interval_i);
  assign w_trigger      = w_interval_hit | w_en_rise;

  assign w_in_load   = (r_state == StLoad);
  // The EDN strobe only goes out when no software strobe owns the port.
  assign w_load_done = w_in_load & ~r_sw_pend;

  // Next-state logic for the IDLE -> REQ -> LOAD -> IDLE sequence.
  always_comb begin
    // NOTE: default first, so no path through the case leaves w_state_d
    // unassigned and no latch is inferred.
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_trigger) w_state_d = StReq;
      StReq:   if (edn_ack_i) w_state_d = StLoad;
      StLoad:  if (!r_sw_pend) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // FSM state and a registered request derived from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_edn_req <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values
      // regardless of statement order.
      r_state   <= w_state_d;
      r_edn_req <= (w_state_d == StReq);
    end
  end

  // Enable edge-detector history and the registered insertion mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en_q <= 1'b0;
      r_mask <= 3'b000;
    end else begin
      r_en_q <= csr_dummy_en_i;
      r_mask <= csr_dummy_mask_i;
    end
  end

  // Insertion counter: counts only in IDLE, saturates, clears when a reseed starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ins_cnt <= '0;
    end else if (r_state == StIdle) begin
      if (w_trigger) begin
        r_ins_cnt <= '0;
      end else if (dummy_inserted_i && csr_dummy_en_i && (r_ins_cnt != '1)) begin
        r_ins_cnt <= r_ins_cnt + InsOne;
      end
    end
  end

  // Capture entropy only when the ack answers an outstanding request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_seed_buf <= '0;
    end else if ((r_state == StReq) && edn_ack_i) begin
      r_seed_buf <= edn_data_i;
    end
  end

  // Software seed write is held for exactly one cycle and then strobed out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw_pend <= 1'b0;
      r_sw_seed <= '0;
    end else begin
      r_sw_pend <= csr_seed_wr_i;
      if (csr_seed_wr_i) r_sw_seed <= csr_seed_i;
    end
  end

  // Count completed EDN reseeds, saturating at 255.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_reseed_cnt <= 8'd0;
    end else if (w_load_done && (r_reseed_cnt != 8'hFF)) begin
      r_reseed_cnt <= r_reseed_cnt + 8'd1;
    end
  end

  assign edn_req_o             = r_edn_req;
  assign reseed_busy_o         = (r_state != StIdle);
  assign reseed_cnt_o          = r_reseed_cnt;
  assign dummy_instr_mask_o    = r_mask;
  assign dummy_instr_en_o      = csr_dummy_en_i & ~w_in_load & ~r_sw_pend;
  assign dummy_instr_seed_en_o = r_sw_pend | w_in_load;
  assign dummy_instr_seed_o    = r_sw_pend ? r_sw_seed :
                                 (w_in_load ? r_seed_buf : 32'h0);

endmodule

// File: tb/tb_ibex_dummy_reseed_ctrl.sv
// Bench for ibex_dummy_reseed_ctrl: a table of single-cycle CSR vectors plus
// hand-written sequences for reseed handshakes, collisions, resets and
// counter saturation. A second instance with ReseedOnEnable = 0 sees the
// same enable edges and must never request entropy.
module tb_ibex_dummy_reseed_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  mask;
  logic [15:0] interval;
  logic        seed_wr;
  logic [31:0] seed;
  logic        ins;
  logic        ack;
  logic [31:0] data;

  logic        req, en_o, seed_en, busy;
  logic [2:0]  mask_o;
  logic [31:0] seed_o;
  logic [7:0]  cnt;

  logic        n_req, n_en_o, n_seed_en, n_busy;
  logic [2:0]  n_mask_o;
  logic [31:0] n_seed_o;
  logic [7:0]  n_cnt;
  logic        n_saw_req = 1'b0;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ibex_dummy_reseed_ctrl #(.ReseedIntervalW(16), .ReseedOnEnable(1'b1)) u_dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .csr_dummy_en_i        (en),
    .csr_dummy_mask_i      (mask),
    .csr_reseed_interval_i (interval),
    .csr_seed_wr_i         (seed_wr),
    .csr_seed_i            (seed),
    .dummy_inserted_i      (ins),
    .edn_req_o             (req),
    .edn_ack_i             (ack),
    .edn_data_i            (data),
    .dummy_instr_en_o      (en_o),
    .dummy_instr_mask_o    (mask_o),
    .dummy_instr_seed_en_o (seed_en),
    .dummy_instr_seed_o    (seed_o),
    .reseed_busy_o         (busy),
    .reseed_cnt_o          (cnt)
  );

  ibex_dummy_reseed_ctrl #(.ReseedIntervalW(16), .ReseedOnEnable(1'b0)) u_noedge (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .csr_dummy_en_i        (en),
    .csr_dummy_mask_i      (mask),
    .csr_reseed_interval_i (16'd0),
    .csr_seed_wr_i         (1'b0),
    .csr_seed_i            (32'h0),
    .dummy_inserted_i      (1'b0),
    .edn_req_o             (n_req),
    .edn_ack_i             (ack),
    .edn_data_i            (data),
    .dummy_instr_en_o      (n_en_o),
    .dummy_instr_mask_o    (n_mask_o),
    .dummy_instr_seed_en_o (n_seed_en),
    .dummy_instr_seed_o    (n_seed_o),
    .reseed_busy_o         (n_busy),
    .reseed_cnt_o          (n_cnt)
  );

  // Sticky flag: the edge-insensitive instance must never raise its request.
  always @(negedge clk) if (n_req) n_saw_req <= 1'b1;

  typedef struct {
    logic        en;
    logic [2:0]  mask;
    logic        wr;
    logic [31:0] seed;
    logic        exp_en;
    logic [2:0]  exp_mask;
    logic        exp_seed_en;
    logic [31:0] exp_seed;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case anything unexpectedly stalls the sequence.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{en:1'b1, mask:3'd3, wr:1'b0, seed:32'h0000_0000, exp_en:1'b1, exp_mask:3'd3, exp_seed_en:1'b0, exp_seed:32'h0000_0000};
    vecs[1] = '{en:1'b1, mask:3'd5, wr:1'b1, seed:32'hA5A5_0001, exp_en:1'b0, exp_mask:3'd5, exp_seed_en:1'b1, exp_seed:32'hA5A5_0001};
    vecs[2] = '{en:1'b1, mask:3'd7, wr:1'b1, seed:32'h0000_00FF, exp_en:1'b0, exp_mask:3'd7, exp_seed_en:1'b1, exp_seed:32'h0000_00FF};
    vecs[3] = '{en:1'b1, mask:3'd0, wr:1'b0, seed:32'h1234_0000, exp_en:1'b1, exp_mask:3'd0, exp_seed_en:1'b0, exp_seed:32'h0000_0000};
    vecs[4] = '{en:1'b1, mask:3'd6, wr:1'b1, seed:32'h8000_0000, exp_en:1'b0, exp_mask:3'd6, exp_seed_en:1'b1, exp_seed:32'h8000_0000};
    vecs[5] = '{en:1'b1, mask:3'd1, wr:1'b0, seed:32'h0000_0000, exp_en:1'b1, exp_mask:3'd1, exp_seed_en:1'b0, exp_seed:32'h0000_0000};

    rst_n = 1'b0; en = 1'b0; mask = 3'd0; interval = 16'd0; seed_wr = 1'b0;
    seed = 32'h0; ins = 1'b0; ack = 1'b0; data = 32'h0;

    // Reset state: every output 0.
    #3;
    check("rst_req", req, 0);
    check("rst_en_o", en_o, 0);
    check("rst_mask", mask_o, 0);
    check("rst_seed_en", seed_en, 0);
    check("rst_seed", seed_o, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_req", req, 0);

    // Enable edge with interval 0: request the cycle after the edge.
    en = 1'b1;
    tick();
    check("en_edge_req", req, 1);
    check("en_edge_busy", busy, 1);
    check("en_edge_en_o", en_o, 1);
    ack = 1'b1; data = 32'hCAFE_F00D;
    tick();
    check("en_edge_load_strobe", seed_en, 1);
    check("en_edge_load_seed", seed_o, 32'hCAFE_F00D);
    check("en_edge_load_req", req, 0);
    check("en_edge_load_en_o", en_o, 0);
    ack = 1'b0; data = 32'h0;
    tick();
    check("en_edge_idle_strobe", seed_en, 0);
    check("en_edge_idle_seed", seed_o, 0);
    check("en_edge_idle_busy", busy, 0);
    check("en_edge_cnt", cnt, 1);

    // Table: mask latency, software seed strobes, insertion gating.
    for (int i = 0; i < 6; i++) begin
      en = vecs[i].en; mask = vecs[i].mask; seed_wr = vecs[i].wr; seed = vecs[i].seed;
      tick();
      check($sformatf("vec%0d_en_o", i), en_o, vecs[i].exp_en);
      check($sformatf("vec%0d_mask", i), mask_o, vecs[i].exp_mask);
      check($sformatf("vec%0d_seed_en", i), seed_en, vecs[i].exp_seed_en);
      check($sformatf("vec%0d_seed", i), seed_o, vecs[i].exp_seed);
    end
    seed_wr = 1'b0; seed = 32'h0;

    // Periodic reseed: 4 pulses with interval 4. The counter reaches 4 on the
    // edge ending the 4th pulse; the trigger is seen then and req follows.
    interval = 16'd4;
    for (int i = 0; i < 4; i++) begin
      ins = 1'b1;
      tick();
      check($sformatf("per_pulse%0d_req", i), req, 0);
    end
    ins = 1'b0;
    tick();
    check("per_req_rise", req, 1);
    ins = 1'b1;                       // pulses during REQ/LOAD are discarded
    tick(); check("per_wait1_req", req, 1);
    tick(); check("per_wait2_req", req, 1);
    ack = 1'b1; data = 32'hDEAD_BEEF;
    tick();
    check("per_strobe", seed_en, 1);
    check("per_seed", seed_o, 32'hDEAD_BEEF);
    check("per_cnt_in_load", cnt, 1);
    ack = 1'b0; data = 32'h0;
    tick();
    ins = 1'b0;
    check("per_done_strobe", seed_en, 0);
    check("per_done_busy", busy, 0);
    check("per_cnt", cnt, 2);

    // Three fresh pulses must not reach interval 4 if busy-time pulses were dropped.
    for (int i = 0; i < 3; i++) begin
      ins = 1'b1; tick(); ins = 1'b0;
    end
    tick();
    check("discard_no_req", req, 0);

    // Raise interval, reach ins_cnt = 10, then lower interval to 5.
    interval = 16'd100;
    for (int i = 0; i < 7; i++) begin
      ins = 1'b1; tick(); ins = 1'b0;
    end
    tick();
    check("int100_no_req", req, 0);
    interval = 16'd5;
    tick();
    check("int_lowered_req", req, 1);
    ack = 1'b1; data = 32'h0BAD_F00D;
    tick();
    check("int_lowered_seed", seed_o, 32'h0BAD_F00D);
    ack = 1'b0;
    tick();
    check("int_lowered_cnt", cnt, 3);

    // Spurious ack in IDLE: ignored.
    interval = 16'd0;
    ack = 1'b1; data = 32'hFFFF_FFFF;
    tick();
    check("spur_strobe", seed_en, 0);
    check("spur_busy", busy, 0);
    ack = 1'b0; data = 32'h0;
    tick();
    check("spur_strobe2", seed_en, 0);
    check("spur_cnt", cnt, 3);

    // Software write during REQ, then collision of ack and write.
    en = 1'b0; tick();
    en = 1'b1; tick();
    check("col_req", req, 1);
    seed_wr = 1'b1; seed = 32'h0F0F_0F0F;
    tick();
    check("req_sw_strobe", seed_en, 1);
    check("req_sw_seed", seed_o, 32'h0F0F_0F0F);
    check("req_sw_stays_req", req, 1);
    ack = 1'b1; data = 32'h55AA_55AA; seed = 32'h1234_5678;
    tick();                           // M+1
    check("col_m1_strobe", seed_en, 1);
    check("col_m1_seed", seed_o, 32'h1234_5678);
    check("col_m1_en_o", en_o, 0);
    check("col_m1_busy", busy, 1);
    ack = 1'b0; seed_wr = 1'b0; seed = 32'h0; data = 32'h0;
    tick();                           // M+2
    check("col_m2_strobe", seed_en, 1);
    check("col_m2_seed", seed_o, 32'h55AA_55AA);
    check("col_m2_en_o", en_o, 0);
    check("col_m2_cnt", cnt, 3);
    tick();                           // M+3
    check("col_m3_strobe", seed_en, 0);
    check("col_m3_busy", busy, 0);
    check("col_m3_en_o", en_o, 1);
    check("col_m3_cnt", cnt, 4);

    // Reset while in REQ (enable dropped during REQ does not abort).
    en = 1'b0; tick();
    en = 1'b1; tick();
    check("rreq_req", req, 1);
    en = 1'b0;
    tick();
    check("rreq_en_low_holds", req, 1);
    rst_n = 1'b0;
    #1;
    check("rreq_req0", req, 0);
    check("rreq_busy0", busy, 0);
    check("rreq_strobe0", seed_en, 0);
    check("rreq_seed0", seed_o, 0);
    check("rreq_mask0", mask_o, 0);
    check("rreq_cnt0", cnt, 0);
    check("rreq_en_o0", en_o, 0);
    tick();
    check("rreq_hold_strobe", seed_en, 0);
    rst_n = 1'b1;
    tick();
    check("rreq_after_busy", busy, 0);
    check("rreq_after_req", req, 0);
    en = 1'b1;
    tick();
    check("rreq_resume_req", req, 1);
    ack = 1'b1; data = 32'h600D_CAFE;
    tick();
    check("rreq_resume_seed", seed_o, 32'h600D_CAFE);
    ack = 1'b0;
    tick();
    check("rreq_resume_cnt", cnt, 1);

    // Reset while in LOAD: the strobe disappears immediately.
    en = 1'b0; tick();
    en = 1'b1; tick();
    ack = 1'b1; data = 32'h7777_7777;
    tick();
    check("rload_in_load", seed_en, 1);
    ack = 1'b0; en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rload_strobe0", seed_en, 0);
    check("rload_seed0", seed_o, 0);
    check("rload_busy0", busy, 0);
    check("rload_cnt0", cnt, 0);
    tick();
    check("rload_hold_strobe", seed_en, 0);
    rst_n = 1'b1;
    tick();
    check("rload_after_busy", busy, 0);
    check("rload_after_strobe", seed_en, 0);
    check("rload_after_cnt", cnt, 0);

    // Saturation: 300 enable-edge reseeds, enable dropped during each REQ.
    for (int i = 0; i < 300; i++) begin
      en = 1'b0; tick();
      en = 1'b1; tick();
      if (i == 0) check("sat_first_req", req, 1);
      en = 1'b0; ack = 1'b1; data = 32'(i) ^ 32'hA000_0000;
      tick();
      if (i == 0) check("sat_first_seed", seed_o, 32'hA000_0000);
      ack = 1'b0;
      tick();
      if (i == 254) check("sat_cnt_255", cnt, 255);
    end
    check("sat_cnt_final", cnt, 255);
    check("sat_busy_final", busy, 0);

    // The edge-insensitive instance never requested and never reseeded.
    check("noedge_never_req", n_saw_req, 0);
    check("noedge_cnt", n_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
